// File: rtl/codiq_pkg.sv
// codiq_pkg: constants, types and helpers shared by the O-QPSK modulator.
// Provides sample_t, the IDLE/RUN state enum and the per-channel pulse state.
package codiq_pkg;

    localparam int SAMPLES_PER_CHIP = 25;
    localparam int PULSE_LEN        = 50;
    localparam int AMP              = 7;
    localparam int NW               = 6;

    typedef logic signed [3:0] sample_t;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // act : a pulse is in flight on this channel
    // live: the pulse carries a real chip (0 = underrun, zero amplitude)
    // pos : chip was 1, pulse is positive
    // n   : pulse index 0..PULSE_LEN-1
    typedef struct packed {
        logic          act;
        logic          live;
        logic          pos;
        logic [NW-1:0] n;
    } chan_t;

    localparam chan_t CHAN_RST = '0;

    // Advance one channel by one RUN clock, or restart it on a slot start.
    function automatic chan_t chan_step(
        input chan_t c,
        input logic  start,
        input logic  live,
        input logic  pos
    );
        chan_t r;
        r = c;
        if (start) begin
            r.act  = 1'b1;
            r.live = live;
            r.pos  = pos;
            r.n    = '0;
        end else if (c.act) begin
            if (c.n == NW'(PULSE_LEN - 1)) begin
                r.act = 1'b0;
                r.n   = '0;
            end else begin
                r.n = c.n + NW'(1);
            end
        end
        return r;
    endfunction

    // Apply the chip sign to a ROM magnitude; idle or underrun gives 0.
    function automatic sample_t to_sample(
        input chan_t      c,
        input logic [2:0] mag
    );
        sample_t m;
        m = sample_t'({1'b0, mag});
        if (!(c.act && c.live)) begin
            return '0;
        end
        return c.pos ? m : -m;
    endfunction

endpackage

// File: rtl/half_sine_rom.sv
// half_sine_rom: round(7*sin(pi*n/50)) magnitude, scaled to SCALE (0..7).
// Ports: n (pulse index 0..49) in, mag (unsigned magnitude) out.
module half_sine_rom
    import codiq_pkg::*;
#(
    parameter int SCALE = AMP
) (
    input  logic [5:0] n,
    output logic [2:0] mag
);

    logic [4:0] idx;
    logic [2:0] q;
    logic [6:0] scaled;

    // Quarter-wave table: the falling half reuses n' = 50 - n.
    always_comb begin
        idx = (n > 6'd25) ? 5'(6'd50 - n) : n[4:0];
        case (idx)
            5'd0, 5'd1:                q = 3'd0;
            5'd2, 5'd3:                q = 3'd1;
            5'd4, 5'd5:                q = 3'd2;
            5'd6, 5'd7, 5'd8:          q = 3'd3;
            5'd9, 5'd10, 5'd11:        q = 3'd4;
            5'd12, 5'd13, 5'd14:       q = 3'd5;
            5'd15, 5'd16, 5'd17, 5'd18: q = 3'd6;
            default:                   q = 3'd7;
        endcase
    end

    // Table is built for peak 7; rescale with rounding to the peak wanted.
    assign scaled = 7'(q) * 7'(SCALE) + 7'd3;
    assign mag    = 3'(scaled / 7'd7);

endmodule

// File: rtl/tl_codeur_iq.sv
// tl_codeur_iq: half-sine O-QPSK modulator, even chips on I, odd on Q.
// Ports: clk, resetn, b_in/en_2MHz/ready chip handshake, mem_state,
//        dac_ready stall, IBB/QBB signed 4-bit samples.
module tl_codeur_iq #(
    parameter int SAMPLES_PER_CHIP = codiq_pkg::SAMPLES_PER_CHIP,
    parameter int AMP              = codiq_pkg::AMP
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               b_in,
    input  logic               en_2MHz,
    input  logic               mem_state,
    input  logic               dac_ready,
    output codiq_pkg::sample_t IBB,
    output codiq_pkg::sample_t QBB,
    output logic               ready
);

    import codiq_pkg::*;

    localparam int SW = $clog2(SAMPLES_PER_CHIP);

    state_t        state;
    logic [SW-1:0] s;
    logic          pend_valid;
    logic          pend_bit;
    logic          next_ch;
    chan_t         ch_i;
    chan_t         ch_q;
    chan_t         nx_i;
    chan_t         nx_q;
    logic [2:0]    mag_i;
    logic [2:0]    mag_q;
    logic          capture;
    logic          load;

    assign ready   = mem_state & ~pend_valid;
    assign capture = en_2MHz & ready;

    // Slot start: a chip (or an underrun) goes to next_ch.
    assign load = (state == RUN) && (s == '0) && mem_state;

    assign nx_i = chan_step(ch_i, load & ~next_ch, pend_valid, pend_bit);
    assign nx_q = chan_step(ch_q, load &  next_ch, pend_valid, pend_bit);

    // ROMs look at the next index so the sample lands with its index.
    half_sine_rom #(.SCALE(AMP)) u_rom_i (
        .n   (nx_i.n),
        .mag (mag_i)
    );

    half_sine_rom #(.SCALE(AMP)) u_rom_q (
        .n   (nx_q.n),
        .mag (mag_q)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            s          <= '0;
            pend_valid <= 1'b0;
            pend_bit   <= 1'b0;
            next_ch    <= 1'b0;
            ch_i       <= CHAN_RST;
            ch_q       <= CHAN_RST;
            IBB        <= '0;
            QBB        <= '0;
        end else begin
            // A new capture wins over consumption of the old chip.
            if (capture) begin
                pend_valid <= 1'b1;
                pend_bit   <= b_in;
            end else if (dac_ready && load) begin
                pend_valid <= 1'b0;
            end

            if (dac_ready) begin
                unique case (state)
                    IDLE: begin
                        if (pend_valid && mem_state) begin
                            state <= RUN;
                        end
                    end
                    RUN: begin
                        if (!mem_state && !ch_i.act && !ch_q.act) begin
                            state   <= IDLE;
                            s       <= '0;
                            next_ch <= 1'b0;
                            IBB     <= '0;
                            QBB     <= '0;
                        end else begin
                            if (s == SW'(SAMPLES_PER_CHIP - 1)) begin
                                s <= '0;
                            end else begin
                                s <= s + SW'(1);
                            end
                            ch_i <= nx_i;
                            ch_q <= nx_q;
                            IBB  <= to_sample(nx_i, mag_i);
                            QBB  <= to_sample(nx_q, mag_q);
                            if (load) begin
                                next_ch <= ~next_ch;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tl_codeur_iq.sv
// tb_tl_codeur_iq: self-checking bench for the O-QPSK half-sine modulator.
// Table vectors, random frames with stalls, reset corners.
module tb_tl_codeur_iq;

    logic              clk = 1'b0;
    logic              resetn;
    logic              b_in;
    logic              en_2MHz;
    logic              mem_state;
    logic              dac_ready;
    logic signed [3:0] IBB;
    logic signed [3:0] QBB;
    logic              ready;

    int checks = 0;
    int errors = 0;
    int max_abs = 0;

    bit chips   [0:63];
    int ibb_log [0:1023];
    int qbb_log [0:1023];

    typedef struct {
        logic [2:0] pat;
        int         nch;
        int         t;
        int         ei;
        int         eq;
    } vec_t;

    localparam int NV = 17;
    vec_t vt [0:NV-1];

    tl_codeur_iq #(
        .SAMPLES_PER_CHIP (25),
        .AMP              (7)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .b_in      (b_in),
        .en_2MHz   (en_2MHz),
        .mem_state (mem_state),
        .dac_ready (dac_ready),
        .IBB       (IBB),
        .QBB       (QBB),
        .ready     (ready)
    );

    always #10 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic int rom(input int n);
        real v;
        v = 7.0 * $sin(3.141592653589793 * n / 50.0);
        return $rtoi(v + 0.5);
    endfunction

    // Channel sample at active time t since the first slot start.
    // Chip k starts at 25k; channel `first` carries chips first, first+2..
    function automatic int pulse(input int t, input int first, input int nch);
        int k;
        int n;
        if (t < 0) return 0;
        k = first + 2 * (t / 50);
        n = t % 50;
        if (k >= nch) return 0;
        return chips[k] ? rom(n) : -rom(n);
    endfunction

    task automatic track_abs(input int v);
        int a;
        a = (v < 0) ? -v : v;
        if (a > max_abs) max_abs = a;
    endtask

    // One frame: nch chips via the ready/en handshake, mem_state dropped
    // after the last chip is consumed, optional stall window / random stalls.
    task automatic run_frame(input int nch, input int st0, input int stlen,
                             input bit rnd);
        int t;
        int c;
        int kk;
        int dly;
        int tdrop;
        int tend;
        int falls;
        bit adv;
        bit prev_rdy;
        mem_state = 1'b1;
        dac_ready = 1'b1;
        b_in      = chips[0];
        en_2MHz   = 1'b1;
        tick();
        en_2MHz = 1'b0;
        check("ready_after_capture", int'(ready), 0);
        tick();
        check("ibb_at_run_entry", IBB, 0);
        t        = -1;
        c        = 0;
        kk       = 1;
        dly      = $urandom_range(0, 15);
        falls    = 0;
        prev_rdy = 1'b0;
        tdrop    = 25 * (nch - 1) + 5;
        tend     = 25 * (nch - 1) + 60;
        while (t < tend && c < 4000) begin
            adv = dac_ready;
            tick();
            c++;
            if (adv) t++;
            if (t >= 0) begin
                ibb_log[t] = IBB;
                qbb_log[t] = QBB;
            end
            check($sformatf("IBB t=%0d", t), IBB, pulse(t, 0, nch));
            check($sformatf("QBB t=%0d", t), QBB, pulse(t - 25, 1, nch));
            track_abs(IBB);
            track_abs(QBB);
            if (mem_state && prev_rdy && !ready) falls++;
            prev_rdy = ready;
            en_2MHz  = 1'b0;
            if (kk < nch && ready) begin
                if (dly == 0) begin
                    b_in    = chips[kk];
                    en_2MHz = 1'b1;
                    kk++;
                    dly = $urandom_range(0, 15);
                end else begin
                    dly--;
                end
            end
            if (t >= tdrop) mem_state = 1'b0;
            dac_ready = !((c >= st0 && c < st0 + stlen) ||
                          (rnd && $urandom_range(0, 7) == 0));
        end
        en_2MHz   = 1'b0;
        dac_ready = 1'b1;
        check("frame_completed", t, tend);
        check("chips_sent", kk, nch);
        check("ready_falls", falls, nch - 1);
        repeat (5) tick();
        check("idle_ibb", IBB, 0);
        check("idle_qbb", QBB, 0);
        check("idle_ready", int'(ready), 0);
    endtask

    initial begin
        vt[0]  = '{3'b001, 1,  2,  1, 0};
        vt[1]  = '{3'b001, 1,  5,  2, 0};
        vt[2]  = '{3'b001, 1, 12,  5, 0};
        vt[3]  = '{3'b001, 1, 25,  7, 0};
        vt[4]  = '{3'b001, 1, 38,  5, 0};
        vt[5]  = '{3'b001, 1, 48,  1, 0};
        vt[6]  = '{3'b001, 1, 49,  0, 0};
        vt[7]  = '{3'b000, 1, 12, -5, 0};
        vt[8]  = '{3'b000, 1, 25, -7, 0};
        vt[9]  = '{3'b000, 1, 40, -4, 0};
        vt[10] = '{3'b011, 3, 27,  7, 1};
        vt[11] = '{3'b011, 3, 48,  1, 7};
        vt[12] = '{3'b011, 3, 49,  0, 7};
        vt[13] = '{3'b011, 3, 50,  0, 7};
        vt[14] = '{3'b011, 3, 52, -1, 7};
        vt[15] = '{3'b011, 3, 62, -5, 5};
        vt[16] = '{3'b011, 3, 75, -7, 0};

        resetn    = 1'b0;
        mem_state = 1'b1;
        en_2MHz   = 1'b0;
        b_in      = 1'b0;
        dac_ready = 1'b1;
        repeat (3) tick();
        check("reset_ibb", IBB, 0);
        check("reset_qbb", QBB, 0);
        check("reset_ready", int'(ready), 1);
        resetn = 1'b1;
        repeat (10) tick();
        check("no_chip_ibb", IBB, 0);
        check("no_chip_qbb", QBB, 0);
        check("no_chip_ready", int'(ready), 1);

        for (int i = 0; i < NV; i++) begin
            if (i == 0 || vt[i].pat != vt[i-1].pat ||
                vt[i].nch != vt[i-1].nch) begin
                for (int j = 0; j < 3; j++) chips[j] = vt[i].pat[j];
                run_frame(vt[i].nch, -1, 0, 1'b0);
            end
            check($sformatf("vec%0d IBB t=%0d", i, vt[i].t),
                  ibb_log[vt[i].t], vt[i].ei);
            check($sformatf("vec%0d QBB t=%0d", i, vt[i].t),
                  qbb_log[vt[i].t], vt[i].eq);
        end

        for (int j = 0; j < 16; j++) chips[j] = 1'($urandom_range(0, 1));
        run_frame(16, -1, 0, 1'b0);

        for (int j = 0; j < 12; j++) chips[j] = 1'($urandom_range(0, 1));
        run_frame(12, 70, 10, 1'b0);

        for (int j = 0; j < 10; j++) chips[j] = 1'($urandom_range(0, 1));
        run_frame(10, -1, 0, 1'b1);

        check("max_abs_le7", int'(max_abs <= 7), 1);

        mem_state = 1'b1;
        dac_ready = 1'b1;
        b_in      = 1'b1;
        en_2MHz   = 1'b1;
        tick();
        en_2MHz = 1'b0;
        tick();
        repeat (26) tick();
        check("pre_reset_ibb", IBB, 7);
        #3;
        resetn = 1'b0;
        #1;
        check("async_reset_ibb", IBB, 0);
        check("async_reset_qbb", QBB, 0);
        check("async_reset_ready", int'(ready), 1);
        tick();
        resetn = 1'b1;
        repeat (30) tick();
        check("post_reset_ibb", IBB, 0);
        check("post_reset_qbb", QBB, 0);
        check("post_reset_ready", int'(ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
